multicycle_ctrl: RTL and testbench

- Moore-style control FSM that sequences the shared MIPS multicycle datapath: single memory port, one ALU, IR/PC/ALUOut registers.
- Supports RTYPE, LW, SW, BEQ, BNE, ADDI, SLTI, J and JR, with the same ALU-op encoding as the existing single-cycle decoder.
- Adds a memory-ready handshake so instruction and data accesses can stall.
- Illegal opcodes trap into a sticky TRAP state.

---
 rtl/mips_ctrl_pkg.sv | 146 ++++++++++++++
 rtl/multicycle_ctrl_if.sv | 37 +++
 rtl/ctrl_pcen.sv | 15 +
 rtl/multicycle_ctrl.sv | 96 +++++++++
 tb/tb_multicycle_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types, encodings and state decode for the multicycle controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    ADDIEX = 4'd8,
    SLTIEX = 4'd9,
    IMMWB  = 4'd10,
    BEQ_S  = 4'd11,
    BNE_S  = 4'd12,
    JUMP   = 4'd13,
    JREG   = 4'd14,
    TRAP   = 4'd15
  } state_t;

  // IR[31:26] opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // IR[5:0] funct codes that change sequencing
  localparam logic [5:0] FN_JR = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  // Per-state control word; fetch marks the state whose IR/PC writes wait on mem_ready
  typedef struct packed {
    logic       fetch;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  // Moore decode: control word for a given state, every unlisted field 0
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch   = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.aluop   = ALUOP_ADD;
        c.pcsrc   = PCSRC_ALU;
      end
      DECODE: begin
        c.alusrcb = SRCB_IMMSH;
        c.aluop   = ALUOP_ADD;
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      MEMRD: c.iord = 1'b1;
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_RT;
        c.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      SLTIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_SLT;
      end
      IMMWB: c.regwrite = 1'b1;
      BEQ_S: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_RT;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PCSRC_ALUOUT;
        c.branch  = 1'b1;
      end
      BNE_S: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = SRCB_RT;
        c.aluop    = ALUOP_SUB;
        c.pcsrc    = PCSRC_ALUOUT;
        c.branchne = 1'b1;
      end
      JUMP: begin
        c.pcsrc   = PCSRC_JUMP;
        c.pcwrite = 1'b1;
      end
      JREG: begin
        c.pcsrc   = PCSRC_RS;
        c.pcwrite = 1'b1;
      end
      TRAP: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller/datapath signal bundle
interface multicycle_ctrl_if;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic       memwrite;
  logic       regwrite;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       illegal;
  logic [3:0] state_o;

  // Controller side
  modport master (
    input  op, funct, zero, mem_ready,
    output iord, irwrite, pcen, memwrite, regwrite, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, aluop, illegal, state_o
  );

  // Datapath side
  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, irwrite, pcen, memwrite, regwrite, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, aluop, illegal, state_o
  );

endinterface

// File: rtl/ctrl_pcen.sv
// rtl/ctrl_pcen.sv - PC load enable from unconditional and conditional branch requests
module ctrl_pcen (
  input  logic pcwrite,
  input  logic branch,
  input  logic branchne,
  input  logic zero,
  output logic pcen
);

  // BEQ loads on equal, BNE on not-equal, jumps and fetch unconditionally
  always_comb begin
    pcen = pcwrite | (branch & zero) | (branchne & ~zero);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for the MIPS multicycle datapath
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  state_t state_q;
  state_t state_n;
  ctrl_t  ctl_q;
  logic   fetch_go;
  logic   pcwrite;
  logic   pcen_raw;

  // Next-state selection; stalls hold FETCH, MEMRD and MEMWR until mem_ready
  always_comb begin
    state_n = state_q;
    case (state_q)
      FETCH:  state_n = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE:     state_n = (bus.funct == FN_JR) ? JREG : EXEC;
          OP_BEQ:       state_n = BEQ_S;
          OP_BNE:       state_n = BNE_S;
          OP_ADDI:      state_n = ADDIEX;
          OP_SLTI:      state_n = SLTIEX;
          OP_J:         state_n = JUMP;
          default:      state_n = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        endcase
      end
      MEMADR: state_n = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_n = bus.mem_ready ? MEMWB : MEMRD;
      MEMWB:  state_n = FETCH;
      MEMWR:  state_n = bus.mem_ready ? FETCH : MEMWR;
      EXEC:   state_n = ALUWB;
      ALUWB:  state_n = FETCH;
      ADDIEX: state_n = IMMWB;
      SLTIEX: state_n = IMMWB;
      IMMWB:  state_n = FETCH;
      BEQ_S:  state_n = FETCH;
      BNE_S:  state_n = FETCH;
      JUMP:   state_n = FETCH;
      JREG:   state_n = FETCH;
      TRAP:   state_n = TRAP;
      default: state_n = FETCH;
    endcase
  end

  // State and its control word are registered together so outputs come straight off flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      ctl_q   <= decode_state(FETCH);
    end else begin
      state_q <= state_n;
      ctl_q   <= decode_state(state_n);
    end
  end

  // Only the fetch strobes depend on mem_ready; reset masks every enable directly
  always_comb begin
    fetch_go = ctl_q.fetch & bus.mem_ready & reset;
    pcwrite  = (ctl_q.pcwrite & reset) | fetch_go;
  end

  ctrl_pcen u_pcen (
    .pcwrite  (pcwrite),
    .branch   (ctl_q.branch),
    .branchne (ctl_q.branchne),
    .zero     (bus.zero),
    .pcen     (pcen_raw)
  );

  // Output drive; write strobes are ANDed with reset so an asserted reset can never pass one
  always_comb begin
    bus.iord     = ctl_q.iord;
    bus.irwrite  = fetch_go;
    bus.pcen     = pcen_raw & reset;
    bus.memwrite = ctl_q.memwrite & reset;
    bus.regwrite = ctl_q.regwrite & reset;
    bus.memtoreg = ctl_q.memtoreg;
    bus.regdst   = ctl_q.regdst;
    bus.alusrca  = ctl_q.alusrca;
    bus.alusrcb  = ctl_q.alusrcb;
    bus.pcsrc    = ctl_q.pcsrc;
    bus.aluop    = ctl_q.aluop;
    bus.illegal  = ctl_q.illegal & reset;
    bus.state_o  = state_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed vector bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_BNE   = 6'b000101;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_SLTI  = 6'b001010;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_ILL   = 6'b111111;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_JR    = 6'b001000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op_r;
  logic [5:0] funct_r;
  logic       zero_r;
  logic       mr_r;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus0 ();
  multicycle_ctrl_if bus1 ();

  assign bus0.op        = op_r;
  assign bus0.funct     = funct_r;
  assign bus0.zero      = zero_r;
  assign bus0.mem_ready = mr_r;
  assign bus1.op        = op_r;
  assign bus1.funct     = funct_r;
  assign bus1.zero      = zero_r;
  assign bus1.mem_ready = mr_r;

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

  // {iord, irwrite, pcen, memwrite, regwrite, memtoreg, regdst, alusrca, alusrcb, pcsrc, aluop, illegal}
  logic [14:0] o0;
  logic [14:0] o1;
  assign o0 = {bus0.iord, bus0.irwrite, bus0.pcen, bus0.memwrite, bus0.regwrite, bus0.memtoreg,
               bus0.regdst, bus0.alusrca, bus0.alusrcb, bus0.pcsrc, bus0.aluop, bus0.illegal};
  assign o1 = {bus1.iord, bus1.irwrite, bus1.pcen, bus1.memwrite, bus1.regwrite, bus1.memtoreg,
               bus1.regdst, bus1.alusrca, bus1.alusrcb, bus1.pcsrc, bus1.aluop, bus1.illegal};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       z;
    logic       m;
    logic [3:0] st;
    logic [7:0] en;
    logic [5:0] sel;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] op, input logic [5:0] funct, input logic z, input logic m,
                     input logic [3:0] st, input logic [7:0] en, input logic [5:0] sel);
    vec_t v;
    v.op = op; v.funct = funct; v.z = z; v.m = m; v.st = st; v.en = en; v.sel = sel;
    tbl.push_back(v);
  endtask

  task automatic check_st(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: state_o got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, check dut0 just after they settle
  task automatic step(input string name, input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic m, input logic [3:0] st, input logic [7:0] en,
                      input logic [5:0] sel, input logic ill);
    @(negedge clk);
    rst_n = r; op_r = o; funct_r = f; zero_r = z; mr_r = m;
    #1;
    check_st({name, " st"}, bus0.state_o, st);
    check_out({name, " out"}, o0, {en, sel, ill});
  endtask

  initial begin
    rst_n = 1'b0; op_r = T_SW; funct_r = 6'b0; zero_r = 1'b0; mr_r = 1'b1;

    // Reset values with mem_ready high: fetch strobes must stay masked
    step("reset", 1'b0, T_SW, 6'b0, 1'b0, 1'b1, 4'd0, 8'b0000_0000, 6'b01_00_00, 1'b0);

    // SW into MEMWR, then reset for three cycles in the middle of the write
    step("sw_fetch", 1'b1, T_SW, 6'b0, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00, 1'b0);
    step("sw_dec",   1'b1, T_SW, 6'b0, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00, 1'b0);
    step("sw_adr",   1'b1, T_SW, 6'b0, 1'b0, 1'b0, 4'd2, 8'b0000_0001, 6'b10_00_00, 1'b0);
    step("sw_wr",    1'b1, T_SW, 6'b0, 1'b0, 1'b0, 4'd5, 8'b1001_0000, 6'b00_00_00, 1'b0);
    for (int i = 0; i < 3; i++)
      step("rst_memwr", 1'b0, T_SW, 6'b0, 1'b0, 1'b0, 4'd0, 8'b0000_0000, 6'b01_00_00, 1'b0);
    step("rst_release", 1'b1, T_LW, 6'b0, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00, 1'b0);

    // LW (fetch done above) with two MEMRD stall cycles
    add(T_LW, 6'b0, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00);
    add(T_LW, 6'b0, 1'b0, 1'b0, 4'd2, 8'b0000_0001, 6'b10_00_00);
    add(T_LW, 6'b0, 1'b0, 1'b0, 4'd3, 8'b1000_0000, 6'b00_00_00);
    add(T_LW, 6'b0, 1'b0, 1'b0, 4'd3, 8'b1000_0000, 6'b00_00_00);
    add(T_LW, 6'b0, 1'b0, 1'b1, 4'd3, 8'b1000_0000, 6'b00_00_00);
    add(T_LW, 6'b0, 1'b0, 1'b0, 4'd4, 8'b0000_1100, 6'b00_00_00);
    // SW with one FETCH stall and one MEMWR stall
    add(T_SW, 6'b0, 1'b0, 1'b0, 4'd0, 8'b0000_0000, 6'b01_00_00);
    add(T_SW, 6'b0, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00);
    add(T_SW, 6'b0, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00);
    add(T_SW, 6'b0, 1'b0, 1'b0, 4'd2, 8'b0000_0001, 6'b10_00_00);
    add(T_SW, 6'b0, 1'b0, 1'b0, 4'd5, 8'b1001_0000, 6'b00_00_00);
    add(T_SW, 6'b0, 1'b0, 1'b1, 4'd5, 8'b1001_0000, 6'b00_00_00);
    // BEQ zero=1 (taken), BNE zero=1 (not taken)
    add(T_BEQ, 6'b0, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00);
    add(T_BEQ, 6'b0, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00);
    add(T_BEQ, 6'b0, 1'b1, 1'b0, 4'd11, 8'b0010_0001, 6'b00_01_01);
    add(T_BNE, 6'b0, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00);
    add(T_BNE, 6'b0, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00);
    add(T_BNE, 6'b0, 1'b1, 1'b0, 4'd12, 8'b0000_0001, 6'b00_01_01);
    // BEQ zero=0 (not taken), BNE zero=0 (taken)
    add(T_BEQ, 6'b0, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00);
    add(T_BEQ, 6'b0, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00);
    add(T_BEQ, 6'b0, 1'b0, 1'b0, 4'd11, 8'b0000_0001, 6'b00_01_01);
    add(T_BNE, 6'b0, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00);
    add(T_BNE, 6'b0, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00);
    add(T_BNE, 6'b0, 1'b0, 1'b0, 4'd12, 8'b0010_0001, 6'b00_01_01);
    // RTYPE add
    add(T_RTYPE, F_ADD, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00);
    add(T_RTYPE, F_ADD, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00);
    add(T_RTYPE, F_ADD, 1'b0, 1'b0, 4'd6, 8'b0000_0001, 6'b00_00_10);
    add(T_RTYPE, F_ADD, 1'b0, 1'b0, 4'd7, 8'b0000_1010, 6'b00_00_00);
    // JR
    add(T_RTYPE, F_JR, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00);
    add(T_RTYPE, F_JR, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00);
    add(T_RTYPE, F_JR, 1'b0, 1'b0, 4'd14, 8'b0010_0000, 6'b00_11_00);
    // ADDI
    add(T_ADDI, 6'b0, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00);
    add(T_ADDI, 6'b0, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00);
    add(T_ADDI, 6'b0, 1'b0, 1'b0, 4'd8, 8'b0000_0001, 6'b10_00_00);
    add(T_ADDI, 6'b0, 1'b0, 1'b0, 4'd10, 8'b0000_1000, 6'b00_00_00);
    // SLTI
    add(T_SLTI, 6'b0, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00);
    add(T_SLTI, 6'b0, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00);
    add(T_SLTI, 6'b0, 1'b0, 1'b0, 4'd9, 8'b0000_0001, 6'b10_00_11);
    add(T_SLTI, 6'b0, 1'b0, 1'b0, 4'd10, 8'b0000_1000, 6'b00_00_00);
    // J
    add(T_J, 6'b0, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00);
    add(T_J, 6'b0, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00);
    add(T_J, 6'b0, 1'b0, 1'b0, 4'd13, 8'b0010_0000, 6'b00_10_00);

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), 1'b1, tbl[i].op, tbl[i].funct, tbl[i].z, tbl[i].m,
           tbl[i].st, tbl[i].en, tbl[i].sel, 1'b0);

    // Illegal opcode: dut0 traps and sticks, dut1 falls back to FETCH
    step("ill_fetch", 1'b1, T_ILL, 6'b0, 1'b0, 1'b1, 4'd0, 8'b0110_0000, 6'b01_00_00, 1'b0);
    step("ill_dec",   1'b1, T_ILL, 6'b0, 1'b0, 1'b0, 4'd1, 8'b0000_0000, 6'b11_00_00, 1'b0);
    check_st("ill_dec nop", bus1.state_o, 4'd1);
    for (int i = 0; i < 20; i++) begin
      step("trap", 1'b1, T_ILL, 6'b0, i[0], 1'b0, 4'd15, 8'b0000_0000, 6'b00_00_00, 1'b1);
      check_st("nop st", bus1.state_o, 4'd0);
      check_out("nop out", o1, {8'b0000_0000, 6'b01_00_00, 1'b0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
